execute_md: RTL

- Parameterised execute (_e) pipeline stage for the RISC-V core.
- Holds the D->E pipeline register, operand forwarding muxes and an ALU.
- Adds an iterative RV M-extension multiply/divide unit that holds the stage via md_busy_e for the hazard unit.
- Sits between decode and memory. Width is generalised by XLEN.

---
 rtl/execute_md.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_md.sv
// Execute stage of the RISC-V core: D->E pipeline register, operand forwarding, ALU and an
// iterative M-extension multiply/divide unit. Build option MULDIV_FAST_EN lets trivial M-ops skip iteration.
module execute_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            rd_write_d,
    input  logic            mem_write_d,
    input  logic [1:0]      rd_write_src_d,
    input  logic [2:0]      alu_op_d,
    input  logic            md_en_d,
    input  logic [2:0]      md_op_d,
    input  logic            alu_src_a_d,
    input  logic            alu_src_b_d,
    input  logic [4:0]      rd_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] rs1_data_d,
    input  logic [XLEN-1:0] rs2_data_d,
    input  logic [1:0]      forwarding_rs1_e,
    input  logic [1:0]      forwarding_rs2_e,
    input  logic [XLEN-1:0] alu_res_m,
    input  logic [XLEN-1:0] rd_data_w,
    output logic            rd_write_e,
    output logic            mem_write_e,
    output logic [1:0]      rd_write_src_e,
    output logic [4:0]      rd_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] alu_res_e,
    output logic [XLEN-1:0] mem_data_e,
    output logic            md_busy_e
);
    localparam int SHW   = (XLEN == 64) ? 6 : 5;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    logic            md_en_e;
    logic [2:0]      md_op_e;
    logic [2:0]      alu_op_e;
    logic            alu_src_a_e;
    logic            alu_src_b_e;
    logic [XLEN-1:0] imm_e;
    logic [XLEN-1:0] rs1_data_e;
    logic [XLEN-1:0] rs2_data_e;

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_out_s;

    md_state_t         state_r;
    md_state_t         state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2:0]        mop_r;
    logic              neg_r;
    logic              rneg_r;
    logic              dz_r;
    logic              ovf_r;
    logic [XLEN-1:0]   dvd_r;

    logic              a_sgn_s;
    logic              b_sgn_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              is_div_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              fast_hit_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_sh_s;
    logic [XLEN-1:0]   div_sub_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] step_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   md_res_s;

    // D->E pipeline register; flush wins over stall
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            rd_write_e     <= 1'b0;
            mem_write_e    <= 1'b0;
            rd_write_src_e <= 2'b00;
            alu_op_e       <= 3'b000;
            md_en_e        <= 1'b0;
            md_op_e        <= 3'b000;
            alu_src_a_e    <= 1'b0;
            alu_src_b_e    <= 1'b0;
            rd_e           <= 5'd0;
            rs1_e          <= 5'd0;
            rs2_e          <= 5'd0;
            imm_e          <= '0;
            pc_e           <= '0;
            rs1_data_e     <= '0;
            rs2_data_e     <= '0;
        end else if (!stall_e) begin
            rd_write_e     <= rd_write_d;
            mem_write_e    <= mem_write_d;
            rd_write_src_e <= rd_write_src_d;
            alu_op_e       <= alu_op_d;
            md_en_e        <= md_en_d;
            md_op_e        <= md_op_d;
            alu_src_a_e    <= alu_src_a_d;
            alu_src_b_e    <= alu_src_b_d;
            rd_e           <= rd_d;
            rs1_e          <= rs1_d;
            rs2_e          <= rs2_d;
            imm_e          <= imm_d;
            pc_e           <= pc_d;
            rs1_data_e     <= rs1_data_d;
            rs2_data_e     <= rs2_data_d;
        end
    end

    // Operand forwarding muxes
    always_comb begin
        fwd_a_s = rs1_data_e;
        fwd_b_s = rs2_data_e;
        case (forwarding_rs1_e)
            2'b01:   fwd_a_s = rd_data_w;
            2'b10:   fwd_a_s = alu_res_m;
            default: fwd_a_s = rs1_data_e;
        endcase
        case (forwarding_rs2_e)
            2'b01:   fwd_b_s = rd_data_w;
            2'b10:   fwd_b_s = alu_res_m;
            default: fwd_b_s = rs2_data_e;
        endcase
    end

    assign op_a_s     = alu_src_a_e ? pc_e : fwd_a_s;
    assign op_b_s     = alu_src_b_e ? imm_e : fwd_b_s;
    assign shamt_s    = op_b_s[SHW-1:0];
    assign mem_data_e = fwd_b_s;

    // ALU
    always_comb begin
        alu_out_s = '0;
        case (alu_op_e)
            3'b000:  alu_out_s = op_a_s + op_b_s;
            3'b001:  alu_out_s = op_a_s - op_b_s;
            3'b010:  alu_out_s = op_a_s & op_b_s;
            3'b011:  alu_out_s = op_a_s | op_b_s;
            3'b100:  alu_out_s = op_a_s ^ op_b_s;
            3'b101:  alu_out_s = op_a_s << shamt_s;
            3'b110:  alu_out_s = op_a_s >> shamt_s;
            3'b111:  alu_out_s = $unsigned($signed(op_a_s) >>> shamt_s);
            default: alu_out_s = '0;
        endcase
    end

    // Operand signedness per funct3
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (md_op_e)
            3'b001, 3'b100, 3'b110: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b1;
            end
            3'b010:  a_sgn_s = 1'b1;
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s    = a_sgn_s & fwd_a_s[XLEN-1];
    assign b_neg_s    = b_sgn_s & fwd_b_s[XLEN-1];
    assign a_mag_s    = a_neg_s ? -fwd_a_s : fwd_a_s;
    assign b_mag_s    = b_neg_s ? -fwd_b_s : fwd_b_s;
    assign is_div_s   = md_op_e[2];
    assign div_zero_s = is_div_s & (fwd_b_s == '0);
    assign div_ovf_s  = is_div_s & a_sgn_s & (fwd_a_s == MOST_NEG) & (fwd_b_s == '1);

`ifdef MULDIV_FAST_EN
    logic mul_zero_s;
    assign mul_zero_s = !is_div_s & ((fwd_a_s == '0) | (fwd_b_s == '0));
    assign fast_hit_s = div_zero_s | div_ovf_s | mul_zero_s;
`else
    assign fast_hit_s = 1'b0;
`endif

    // One radix-2 step: shift-add multiply or restoring divide sharing prod_r {hi, lo}
    always_comb begin
        mul_sum_s = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, mcand_r & {XLEN{prod_r[0]}}};
        div_sh_s  = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
        div_ge_s  = (div_sh_s >= {1'b0, mcand_r});
        div_sub_s = div_sh_s[XLEN-1:0] - mcand_r;
        if (mop_r[2]) begin
            step_s = {(div_ge_s ? div_sub_s : div_sh_s[XLEN-1:0]), prod_r[XLEN-2:0], div_ge_s};
        end else begin
            step_s = {mul_sum_s, prod_r[XLEN-1:1]};
        end
    end

    // Apply signs and the divide corner cases to the magnitude result
    always_comb begin
        prod_fix_s = neg_r ? -prod_r : prod_r;
        quo_s      = neg_r ? -prod_r[XLEN-1:0] : prod_r[XLEN-1:0];
        rem_s      = rneg_r ? -prod_r[2*XLEN-1:XLEN] : prod_r[2*XLEN-1:XLEN];
        md_res_s   = '0;
        case (mop_r)
            3'b000:                 md_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res_s = dz_r ? '1 : (ovf_r ? dvd_r : quo_s);
            3'b110, 3'b111:         md_res_s = dz_r ? dvd_r : (ovf_r ? '0 : rem_s);
            default:                md_res_s = '0;
        endcase
    end

    // M FSM state register
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // M FSM next state and busy flag
    always_comb begin
        state_s   = state_r;
        md_busy_e = 1'b0;
        case (state_r)
            MD_IDLE: begin
                md_busy_e = md_en_e;
                if (md_en_e) begin
                    state_s = fast_hit_s ? MD_DONE : MD_BUSY;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                md_busy_e = 1'b1;
                if (cnt_r == '0) begin
                    state_s = MD_DONE;
                end else begin
                    state_s = MD_BUSY;
                end
            end
            MD_DONE: begin
                if (!stall_e) begin
                    state_s = MD_IDLE;
                end else begin
                    state_s = MD_DONE;
                end
            end
            default: state_s = MD_IDLE;
        endcase
    end

    // M datapath: capture operands in IDLE, iterate in BUSY, hold otherwise
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            cnt_r   <= '0;
            prod_r  <= '0;
            mcand_r <= '0;
            mop_r   <= 3'b000;
            neg_r   <= 1'b0;
            rneg_r  <= 1'b0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            dvd_r   <= '0;
        end else if ((state_r == MD_IDLE) && md_en_e) begin
            cnt_r   <= CNT_W'(XLEN-1);
            prod_r  <= fast_hit_s ? '0 : {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            mcand_r <= is_div_s ? b_mag_s : a_mag_s;
            mop_r   <= md_op_e;
            neg_r   <= a_neg_s ^ b_neg_s;
            rneg_r  <= a_neg_s;
            dz_r    <= div_zero_s;
            ovf_r   <= div_ovf_s;
            dvd_r   <= fwd_a_s;
        end else if (state_r == MD_BUSY) begin
            prod_r <= step_s;
            cnt_r  <= cnt_r - CNT_W'(1);
        end
    end

    assign alu_res_e = (state_r == MD_DONE) ? md_res_s : alu_out_s;

endmodule
